// File: rtl/pio_mailbox_bank_if.sv
// Bundles the Avalon-MM slave and the hardware-side bank handshakes of pio_mailbox_bank.
// slave = the mailbox itself; master = the CPU/fabric and the game hardware driving it.
interface pio_mailbox_bank_if #(
    parameter int W    = 32,
    parameter int N_HW = 16,
    parameter int N_SW = 3
);
    logic [5:0]          avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [31:0]         avs_writedata;
    logic [31:0]         avs_readdata;
    logic [N_HW*W-1:0]   hw_data;
    logic                hw_valid;
    logic                hw_ready;
    logic [N_SW*W-1:0]   sw_data;
    logic                sw_valid;
    logic                sw_ready;
    logic                irq;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, hw_ready, sw_data, sw_valid,
        output avs_readdata, hw_data, hw_valid, sw_ready, irq
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, hw_ready, sw_data, sw_valid,
        input  avs_readdata, hw_data, hw_valid, sw_ready, irq
    );
endinterface

// File: rtl/pio_mailbox_bank.sv
// Handshaked PIO mailbox: staged to-hardware bank committed atomically, to-software bank captured until released.
// Latency: readdata 1 cycle, commit/capture visible after the causing edge, irq one cycle behind its flag.
// Backpressure: hw_valid held until hw_ready; sw_ready low while the capture is unreleased. Optional irq: PIO_MAILBOX_IRQ_EN.
module pio_mailbox_bank #(
    parameter int W    = 32,
    parameter int N_HW = 16,
    parameter int N_SW = 3
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    pio_mailbox_bank_if.slave   bus
);
    typedef enum logic {IDLE, PEND} state_e;

    state_e              state_q;
    logic [N_HW*W-1:0]   shadow_q;
    logic [W-1:0]        stg_q [N_HW];
    logic [W-1:0]        cap_q [N_SW];
    logic                sw_full_q;
    logic                ovr_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;
    logic [N_HW*W-1:0]   stg_flat;
    logic                ie;
    logic [31:0]         wd_unused;

    logic wr_ctrl, commit, rel, clr_ovr, commit_ok, capture;

    assign wd_unused = bus.avs_writedata;
    assign wr_ctrl   = bus.avs_write && (bus.avs_address == 6'd0);
    assign commit    = wr_ctrl && bus.avs_writedata[0];
    assign rel       = wr_ctrl && bus.avs_writedata[1];
    assign clr_ovr   = wr_ctrl && bus.avs_writedata[2];
    // A commit while pending only lands if the old bank is being accepted on the same edge.
    assign commit_ok = commit && ((state_q == IDLE) || bus.hw_ready);
    assign capture   = bus.sw_valid && !sw_full_q;

    always_comb begin
        stg_flat = '0;
        for (int i = 0; i < N_HW; i++) stg_flat[i*W +: W] = stg_q[i];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (commit) begin
                    shadow_q <= stg_flat;
                    state_q  <= PEND;
                end
                PEND: if (bus.hw_ready) begin
                    if (commit) shadow_q <= stg_flat;
                    else        state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (bus.avs_address == 6'd0)
            rdata_d = {27'd0, ie, 1'b0, ovr_q, sw_full_q, state_q == PEND};
        for (int i = 0; i < N_HW; i++)
            if (bus.avs_address == 6'(i + 1)) rdata_d[W-1:0] = stg_q[i];
        for (int j = 0; j < N_SW; j++)
            if (bus.avs_address == 6'(N_HW + 1 + j)) rdata_d[W-1:0] = cap_q[j];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < N_HW; i++) stg_q[i] <= '0;
            for (int j = 0; j < N_SW; j++) cap_q[j] <= '0;
            sw_full_q <= 1'b0;
            ovr_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            for (int i = 0; i < N_HW; i++)
                if (bus.avs_write && bus.avs_address == 6'(i + 1))
                    stg_q[i] <= bus.avs_writedata[W-1:0];
            if (capture) begin
                for (int j = 0; j < N_SW; j++) cap_q[j] <= bus.sw_data[j*W +: W];
                sw_full_q <= 1'b1;
            end else if (rel) begin
                sw_full_q <= 1'b0;
            end
            if (commit && !commit_ok) ovr_q <= 1'b1;
            else if (clr_ovr)         ovr_q <= 1'b0;
            if (bus.avs_read) rdata_q <= rdata_d;
        end
    end

`ifdef PIO_MAILBOX_IRQ_EN
    logic ie_q;
    logic irq_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_ctrl) ie_q <= bus.avs_writedata[4];
            irq_q <= ie_q && (sw_full_q || ovr_q);
        end
    end

    assign ie      = ie_q;
    assign bus.irq = irq_q;
`else
    assign ie      = 1'b0;
    assign bus.irq = 1'b0;
`endif

    assign bus.avs_readdata = rdata_q;
    assign bus.hw_data      = shadow_q;
    assign bus.hw_valid     = (state_q == PEND);
    assign bus.sw_ready     = !sw_full_q;
endmodule

// File: tb/tb_pio_mailbox_bank.sv
// Bench for pio_mailbox_bank: directed scenarios on a 32x16/3 instance and an 8-bit 2/1 instance,
// then randomized traffic against a behavioural mailbox model.
module tb_pio_mailbox_bank;
`ifdef PIO_MAILBOX_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst8 = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pio_mailbox_bank_if #(.W(32), .N_HW(16), .N_SW(3)) b ();
    pio_mailbox_bank_if #(.W(8),  .N_HW(2),  .N_SW(1)) b8 ();

    pio_mailbox_bank #(.W(32), .N_HW(16), .N_SW(3)) dut (
        .clk_clk(clk), .reset_reset(rst), .bus(b.slave));
    pio_mailbox_bank #(.W(8), .N_HW(2), .N_SW(1)) dut8 (
        .clk_clk(clk), .reset_reset(rst8), .bus(b8.slave));

    initial begin
        b.avs_address = '0; b.avs_read = 0; b.avs_write = 0; b.avs_writedata = '0;
        b.hw_ready = 0; b.sw_data = '0; b.sw_valid = 0;
        b8.avs_address = '0; b8.avs_read = 0; b8.avs_write = 0; b8.avs_writedata = '0;
        b8.hw_ready = 0; b8.sw_data = '0; b8.sw_valid = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        b.avs_address = a; b.avs_writedata = d; b.avs_write = 1'b1;
        tick();
        b.avs_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        b.avs_address = a; b.avs_read = 1'b1;
        tick();
        b.avs_read = 1'b0;
        d = b.avs_readdata;
    endtask

    task automatic wr8(input logic [5:0] a, input logic [31:0] d);
        b8.avs_address = a; b8.avs_writedata = d; b8.avs_write = 1'b1;
        tick();
        b8.avs_write = 1'b0;
    endtask

    task automatic rd8(input logic [5:0] a, output logic [31:0] d);
        b8.avs_address = a; b8.avs_read = 1'b1;
        tick();
        b8.avs_read = 1'b0;
        d = b8.avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++; if (b.hw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hw_valid got %b want 0", b.hw_valid); end
        n_tests++; if (b.sw_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sw_ready got %b want 1", b.sw_ready); end
        n_tests++; if (b.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", b.irq); end
        n_tests++; if (b.hw_data !== '0) begin n_fail++; $display("FAIL reset_hw_data got %h want 0", b.hw_data); end
        n_tests++; if (b.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", b.avs_readdata); end
        rd(6'd0, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_stat got %h want 00000000", r); end
    endtask

    task automatic test_commit();
        logic [31:0] r;
        wr(6'd1, 32'hAAAA5555);
        wr(6'd16, 32'h12345678);
        n_tests++; if (b.hw_valid !== 1'b0 || b.hw_data !== '0) begin n_fail++; $display("FAIL staging_isolated valid %b data0 %h want 0/0", b.hw_valid, b.hw_data[31:0]); end
        wr(6'd0, 32'h1);
        n_tests++; if (b.hw_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid got %b want 1", b.hw_valid); end
        n_tests++; if (b.hw_data[0 +: 32] !== 32'hAAAA5555) begin n_fail++; $display("FAIL commit_ch0 got %h want AAAA5555", b.hw_data[0 +: 32]); end
        n_tests++; if (b.hw_data[15*32 +: 32] !== 32'h12345678) begin n_fail++; $display("FAIL commit_ch15 got %h want 12345678", b.hw_data[15*32 +: 32]); end
        rd(6'd0, r);
        n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL commit_stat got %h want 00000001", r); end
        b.hw_ready = 1'b1; tick(); b.hw_ready = 1'b0;
        n_tests++; if (b.hw_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_valid got %b want 0", b.hw_valid); end
        rd(6'd0, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL handshake_stat got %h want 00000000", r); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        wr(6'd0, 32'h1);
        wr(6'd1, 32'h1);
        wr(6'd0, 32'h1);
        n_tests++; if (b.hw_data[0 +: 32] !== 32'hAAAA5555) begin n_fail++; $display("FAIL overrun_hold got %h want AAAA5555", b.hw_data[0 +: 32]); end
        n_tests++; if (b.hw_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid got %b want 1", b.hw_valid); end
        rd(6'd0, r);
        n_tests++; if (r !== 32'h5) begin n_fail++; $display("FAIL overrun_stat got %h want 00000005", r); end
        wr(6'd0, 32'h4);
        rd(6'd0, r);
        n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL clr_ovr_stat got %h want 00000001", r); end
    endtask

    task automatic test_recommit();
        wr(6'd1, 32'hDEADBEEF);
        b.hw_ready = 1'b1;
        wr(6'd0, 32'h1);
        b.hw_ready = 1'b0;
        n_tests++; if (b.hw_valid !== 1'b1) begin n_fail++; $display("FAIL recommit_valid got %b want 1", b.hw_valid); end
        n_tests++; if (b.hw_data[0 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL recommit_ch0 got %h want DEADBEEF", b.hw_data[0 +: 32]); end
        n_tests++; if (b.hw_data[15*32 +: 32] !== 32'h12345678) begin n_fail++; $display("FAIL recommit_ch15 got %h want 12345678", b.hw_data[15*32 +: 32]); end
        b.hw_ready = 1'b1; tick(); b.hw_ready = 1'b0;
        n_tests++; if (b.hw_valid !== 1'b0 || b.hw_data[0 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL recommit_done valid %b ch0 %h want 0/DEADBEEF", b.hw_valid, b.hw_data[0 +: 32]); end
    endtask

    task automatic test_capture();
        logic [31:0] r;
        wr(6'd0, 32'h10);
        b.sw_data = {32'h33333333, 32'h22222222, 32'hCAFEBABE};
        b.sw_valid = 1'b1; tick(); b.sw_valid = 1'b0;
        n_tests++; if (b.sw_ready !== 1'b0) begin n_fail++; $display("FAIL capture_ready got %b want 0", b.sw_ready); end
        n_tests++; if (b.irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got %b want 0", b.irq); end
        tick();
        n_tests++; if (b.irq !== IRQ_EN) begin n_fail++; $display("FAIL capture_irq got %b want %b", b.irq, IRQ_EN); end
        rd(6'd17, r);
        n_tests++; if (r !== 32'hCAFEBABE) begin n_fail++; $display("FAIL capture_ch0 got %h want CAFEBABE", r); end
        rd(6'd19, r);
        n_tests++; if (r !== 32'h33333333) begin n_fail++; $display("FAIL capture_ch2 got %h want 33333333", r); end
        b.sw_data = {3{32'h11111111}};
        b.sw_valid = 1'b1; tick(); b.sw_valid = 1'b0;
        rd(6'd17, r);
        n_tests++; if (r !== 32'hCAFEBABE) begin n_fail++; $display("FAIL capture_locked got %h want CAFEBABE", r); end
        rd(6'd0, r);
        n_tests++; if (r !== (IRQ_EN ? 32'h12 : 32'h2)) begin n_fail++; $display("FAIL capture_stat got %h want %h", r, IRQ_EN ? 32'h12 : 32'h2); end
        b.sw_valid = 1'b1;
        wr(6'd0, 32'h12);
        b.sw_valid = 1'b0;
        n_tests++; if (b.sw_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", b.sw_ready); end
        rd(6'd17, r);
        n_tests++; if (r !== 32'hCAFEBABE) begin n_fail++; $display("FAIL release_no_capture got %h want CAFEBABE", r); end
        n_tests++; if (b.irq !== 1'b0) begin n_fail++; $display("FAIL release_irq got %b want 0", b.irq); end
        b.sw_valid = 1'b1; tick(); b.sw_valid = 1'b0;
        rd(6'd17, r);
        n_tests++; if (r !== 32'h11111111) begin n_fail++; $display("FAIL recapture got %h want 11111111", r); end
        wr(6'd0, 32'h2);
    endtask

    task automatic test_w8();
        logic [31:0] r;
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        wr8(6'd1, 32'hFFFFFF7E);
        rd8(6'd1, r);
        n_tests++; if (r !== 32'h0000007E) begin n_fail++; $display("FAIL w8_trunc got %h want 0000007E", r); end
        rd8(6'd63, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL w8_unmapped got %h want 0", r); end
        wr8(6'd0, 32'h1);
        n_tests++; if (b8.hw_valid !== 1'b1 || b8.hw_data !== 16'h007E) begin n_fail++; $display("FAIL w8_commit valid %b data %h want 1/007E", b8.hw_valid, b8.hw_data); end
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        n_tests++; if (b8.hw_valid !== 1'b0 || b8.hw_data !== 16'h0) begin n_fail++; $display("FAIL w8_reset_abort valid %b data %h want 0/0000", b8.hw_valid, b8.hw_data); end
    endtask

    task automatic test_random();
        logic [31:0]  m_stg [16];
        logic [31:0]  m_sh  [16];
        logic [31:0]  m_cap [3];
        bit           m_pend, m_full, m_ovr, m_ie, m_irq;
        logic [5:0]   a;
        logic [31:0]  d, exp_rd;
        logic [511:0] exp_hw;
        logic [95:0]  sd;
        bit           rd_en, wr_en, hr, sv, commit, captured;
        int           op;

        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin m_stg[i] = '0; m_sh[i] = '0; end
        for (int j = 0; j < 3; j++) m_cap[j] = '0;
        m_pend = 0; m_full = 0; m_ovr = 0; m_ie = 0;

        for (int n = 0; n < 800; n++) begin
            op = $urandom_range(0, 5);
            hr = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 2) == 0);
            sd = {$urandom, $urandom, $urandom};
            d = $urandom;
            a = '0; rd_en = 0; wr_en = 0;
            case (op)
                0: begin wr_en = 1; a = 6'($urandom_range(1, 16)); end
                1: begin wr_en = 1; a = 6'd0; d = d & 32'h17; end
                2: begin rd_en = 1; a = 6'($urandom_range(0, 63)); end
                3: begin wr_en = 1; a = 6'($urandom_range(17, 63)); end
                4: begin rd_en = 1; a = 6'($urandom_range(17, 19)); end
                default: ;
            endcase

            if (a == 0)       exp_rd = {27'd0, m_ie, 1'b0, m_ovr, m_full, m_pend};
            else if (a <= 16) exp_rd = m_stg[a - 1];
            else if (a <= 19) exp_rd = m_cap[a - 17];
            else              exp_rd = 32'h0;
            m_irq = IRQ_EN && m_ie && (m_full || m_ovr);

            b.avs_address = a; b.avs_writedata = d; b.avs_read = rd_en; b.avs_write = wr_en;
            b.hw_ready = hr; b.sw_valid = sv; b.sw_data = sd;
            tick();
            b.avs_read = 0; b.avs_write = 0; b.hw_ready = 0; b.sw_valid = 0;

            commit = wr_en && a == 0 && d[0];
            captured = sv && !m_full;
            if (wr_en && a == 0 && d[2]) m_ovr = 0;
            if (commit && (!m_pend || hr)) begin
                m_sh = m_stg;
                m_pend = 1;
            end else begin
                if (commit) m_ovr = 1;
                if (m_pend && hr) m_pend = 0;
            end
            if (wr_en && a >= 1 && a <= 16) m_stg[a - 1] = d;
            if (wr_en && a == 0 && IRQ_EN) m_ie = d[4];
            if (wr_en && a == 0 && d[1]) m_full = 0;
            if (captured) begin
                m_full = 1;
                for (int j = 0; j < 3; j++) m_cap[j] = sd[j*32 +: 32];
            end
            for (int i = 0; i < 16; i++) exp_hw[i*32 +: 32] = m_sh[i];

            n_tests++; if (b.hw_valid !== m_pend) begin n_fail++; $display("FAIL rnd_hw_valid cyc %0d got %b want %b", n, b.hw_valid, m_pend); end
            n_tests++; if (b.hw_data !== exp_hw) begin n_fail++; $display("FAIL rnd_hw_data cyc %0d got %h want %h", n, b.hw_data, exp_hw); end
            n_tests++; if (b.sw_ready !== !m_full) begin n_fail++; $display("FAIL rnd_sw_ready cyc %0d got %b want %b", n, b.sw_ready, !m_full); end
            n_tests++; if (b.irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq cyc %0d got %b want %b", n, b.irq, m_irq); end
            if (rd_en) begin
                n_tests++; if (b.avs_readdata !== exp_rd) begin n_fail++; $display("FAIL rnd_read cyc %0d addr %0d got %h want %h", n, a, b.avs_readdata, exp_rd); end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_commit();
        test_overrun();
        test_recommit();
        test_capture();
        test_w8();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_mailbox_bank.md
# pio_mailbox_bank

Parametrised successor to the fixed bank of 32-bit PIO ports between the Nios II and game hardware. It provides N_HW software-to-hardware registers and N_SW hardware-to-software registers of configurable width behind one Avalon-MM slave. Unlike free-running PIOs, the transfers use handshakes:
- hardware sees a whole bank update in a single cycle;
- software sees a captured snapshot that hardware cannot change until software releases it.

## Interface
Parameters:
- W, 32: data width per channel, 8..32.
- N_HW, 16: number of to-hardware channels, 1..32.
- N_SW, 3: number of to-software channels, 1..31. Constraint: 1+N_HW+N_SW <= 64.

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  reset; synchronous, active-high.
- avs_address  in  6  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data. Bits above W are ignored.
- avs_readdata  out  32  read data. Fixed latency of 1 cycle. Zero-extended above W.
- hw_data  out  N_HW*W  committed to-hardware bank. Channel i occupies bits [i*W +: W].
- hw_valid  out  1  a committed bank is pending.
- hw_ready  in  1  hardware accepts the pending bank.
- sw_data  in  N_SW*W  to-software bank from hardware. Same packing as hw_data.
- sw_valid  in  1  hardware offers sw_data.
- sw_ready  out  1  capture buffer is empty.
- irq  out  1  level interrupt to the CPU.

## Operation
Address map:
- 0: CTRL/STAT.
- 1..N_HW: to-hardware staging registers, read/write.
- N_HW+1..N_HW+N_SW: to-software capture registers, read-only.
- Any other address: reads 0, writes ignored.

STAT read layout:
- bit0 HW_BUSY
- bit1 SW_FULL
- bit2 OVR (sticky)
- bit4 IE
- all other bits 0

CTRL write bits:
- bit0 COMMIT
- bit1 RELEASE
- bit2 CLR_OVR (write 1 to clear)
- bit4 IE, stored

Commit FSM, states IDLE and PEND:
- IDLE, on COMMIT: copy all staging registers to the hw_data shadow, then go to PEND.
- PEND: hw_valid=1 and hw_data is held stable.
- PEND, when hw_ready=1: return to IDLE.
- COMMIT arriving in PEND in the same cycle as hw_ready=1: accepted. The shadow reloads and the FSM stays in PEND.
- COMMIT arriving in PEND with hw_ready=0: ignored, and OVR is set.
- Staging writes are allowed in any state and never disturb hw_data.

Capture path:
- sw_ready = !SW_FULL.
- When sw_valid && sw_ready: latch sw_data into the capture registers and set SW_FULL.
- RELEASE clears SW_FULL.
- RELEASE and sw_valid in the same cycle: the flag clears. Capture happens no earlier than the next cycle, because sw_ready is registered from SW_FULL.

Interrupt:
- irq = IE && (SW_FULL || OVR).

## Timing
- Reset values:
  - avs_readdata=0, hw_data=0, hw_valid=0, sw_ready=1 after the reset cycle, irq=0.
  - Staging and capture registers, SW_FULL, OVR and IE all reset to 0.
  - FSM resets to IDLE.
- Reset mid-operation aborts a pending commit: hw_valid falls on the next edge.
- A write is effective at the clock edge on which avs_write is high.
- readdata is valid one cycle after avs_read and reflects register state at the read edge.
- Commit latency: COMMIT write at edge k gives hw_valid=1 and the new hw_data visible after edge k.
- Handshake completes at the first edge with hw_valid && hw_ready. hw_valid is low after that edge unless a recommit was accepted on it.
- Capture: sw_valid && sw_ready at edge k gives SW_FULL=1 and sw_ready=0 after edge k, with data readable from k+1.
- irq is registered and follows the causing flag by one cycle.
- No combinational path from any input to any output.

## Configuration
- PIO_MAILBOX_IRQ_EN defined: IE is stored and irq behaves as specified.
- PIO_MAILBOX_IRQ_EN not defined: IE is not implemented and reads 0, irq is tied 0, and no interrupt logic is synthesised. All other behaviour is identical.

## Test plan
- Reset, then read addr 0 -> 0x00000000. Check hw_valid=0, sw_ready=1, irq=0.
- Write 0xAAAA5555 to addr 1 and 0x12345678 to addr 16, then COMMIT with hw_ready=0 -> hw_valid=1, channel0=0xAAAA5555, channel15=0x12345678. STAT=0x1. Raise hw_ready for 1 cycle -> hw_valid=0, STAT=0x0.
- During PEND with hw_ready=0: write addr 1=0x1, then COMMIT -> hw_data unchanged, STAT bit2=1. Write CTRL=0x4 -> OVR cleared.
- COMMIT in the same cycle as hw_ready=1 with staging changed -> hw_valid stays 1 and hw_data shows the new values the next cycle.
- Write IE=1, then pulse sw_valid with channel0=0xCAFEBABE -> sw_ready=0, irq=1, addr N_HW+1 reads 0xCAFEBABE. A second sw_valid with different data is not captured. RELEASE -> irq=0, sw_ready=1.
- W=8 build: write 0xFFFFFF7E to addr 1 -> read returns 0x0000007E. Assert reset mid-PEND -> hw_valid=0 the next cycle.
